wb_bus_watchdog: RTL

- Pipelined-Wishbone stage placed directly upstream of the 1-to-18 peripheral mux, between the CPU data port and the mux slave port.
- Forwards requests and responses with zero added latency.
- Tracks outstanding transactions, throttles at a limit, and aborts any bus cycle that receives no ack/err within a timeout, returning err to the master.
- Prevents a hung or unmapped peripheral from locking the CPU.

---
 rtl/wb_bus_watchdog_if.sv | 22 ++
 rtl/wb_bus_watchdog.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/wb_bus_watchdog_if.sv
// Pipelined-Wishbone bus bundle. The master modport drives requests, the slave modport drives responses.
interface wb_bus_watchdog_if #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int SELECT_WIDTH = DATA_WIDTH/8
);
  logic [ADDR_WIDTH-1:0]   adr;
  logic [DATA_WIDTH-1:0]   dat_w;
  logic [DATA_WIDTH-1:0]   dat_r;
  logic                    we;
  logic [SELECT_WIDTH-1:0] sel;
  logic                    stb;
  logic                    cyc;
  logic                    ack;
  logic                    err;
  logic                    stall;

  modport master (output adr, dat_w, we, sel, stb, cyc,
                  input  dat_r, ack, err, stall);
  modport slave  (input  adr, dat_w, we, sel, stb, cyc,
                  output dat_r, ack, err, stall);
endinterface

// File: rtl/wb_bus_watchdog.sv
// Zero-latency Wishbone stage that caps outstanding requests and aborts hung cycles with err.
// Define WB_WATCHDOG_LOG_EN to add the fault_adr_o / fault_o / fault_clr_i logging ports.
module wb_bus_watchdog #(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 32,
  parameter int SELECT_WIDTH    = DATA_WIDTH/8,
  parameter int TIMEOUT_CYCLES  = 1024,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  wb_bus_watchdog_if.slave      wbm,
  wb_bus_watchdog_if.master     wbs,
`ifdef WB_WATCHDOG_LOG_EN
  output logic [ADDR_WIDTH-1:0] fault_adr_o,
  output logic                  fault_o,
  input  logic                  fault_clr_i,
`endif
  output logic                  timeout_o
);
  localparam int OCNT_W = $clog2(MAX_OUTSTANDING+1);
  localparam int TMR_W  = $clog2(TIMEOUT_CYCLES+1);
  localparam logic [OCNT_W-1:0] MAX_O    = OCNT_W'(MAX_OUTSTANDING);
  localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(TIMEOUT_CYCLES-1);

  typedef enum logic [1:0] {IDLE, BUSY, ABORT, WAIT_CYC} state_e;

  state_e            state_q;
  logic [OCNT_W-1:0] outst_q, outst_d;
  logic [TMR_W-1:0]  timer_q;
  logic              timeout_q;

  logic pass, limit, have, accept, fwd, to_hit, abort_entry;

  assign pass   = (state_q == IDLE) || (state_q == BUSY);
  assign limit  = (outst_q == MAX_O);
  assign have   = (outst_q != '0);
  assign accept = wbs.stb & ~wbs.stall;
  assign fwd    = pass & have & (wbs.ack | wbs.err);
  assign to_hit = (timer_q == TMR_LAST) & ~accept & ~fwd;
  assign abort_entry = (state_q == BUSY) & wbm.cyc & to_hit;
  assign timeout_o = timeout_q;

  // Outputs are gated by rst_n so reset forces them low even while the master keeps cyc up.
  always_comb begin
    wbs.adr   = {ADDR_WIDTH{1'b0}};
    wbs.dat_w = {DATA_WIDTH{1'b0}};
    wbs.we    = 1'b0;
    wbs.sel   = {SELECT_WIDTH{1'b0}};
    wbs.cyc   = 1'b0;
    wbs.stb   = 1'b0;
    wbm.dat_r = {DATA_WIDTH{1'b0}};
    wbm.ack   = 1'b0;
    wbm.err   = 1'b0;
    wbm.stall = 1'b0;
    if (rst_n) begin
      if (pass) begin
        wbs.adr   = wbm.adr;
        wbs.dat_w = wbm.dat_w;
        wbs.we    = wbm.we;
        wbs.sel   = wbm.sel;
        wbs.cyc   = wbm.cyc;
        wbs.stb   = wbm.stb & ~limit;
        wbm.stall = wbs.stall | limit;
        wbm.ack   = wbs.ack & have;
        wbm.err   = wbs.err & have;
        wbm.dat_r = have ? wbs.dat_r : {DATA_WIDTH{1'b0}};
      end else begin
        wbm.stall = 1'b1;
        // First ABORT cycle only announces the timeout; errs follow one per outstanding request.
        if (state_q == ABORT) wbm.err = ~timeout_q & have & wbm.cyc;
      end
    end
  end

  always_comb begin
    outst_d = outst_q;
    if (accept && !fwd)      outst_d = outst_q + 1'b1;
    else if (fwd && !accept) outst_d = outst_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      outst_q   <= '0;
      timer_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      if (!wbm.cyc) begin
        state_q <= IDLE;
        outst_q <= '0;
        timer_q <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            outst_q <= outst_d;
            timer_q <= '0;
            if (accept) state_q <= BUSY;
          end
          BUSY: begin
            if (to_hit) begin
              state_q   <= ABORT;
              timeout_q <= 1'b1;
              timer_q   <= '0;
            end else begin
              outst_q <= outst_d;
              if (outst_d == '0) state_q <= IDLE;
              if (accept || fwd || outst_d == '0) timer_q <= '0;
              else if (timer_q != '1)             timer_q <= timer_q + 1'b1;
            end
          end
          ABORT: begin
            if (!timeout_q) begin
              outst_q <= outst_q - 1'b1;
              if (outst_q == OCNT_W'(1)) state_q <= WAIT_CYC;
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef WB_WATCHDOG_LOG_EN
  logic [ADDR_WIDTH-1:0] last_adr_q, fault_adr_q;
  logic                  fault_q;

  assign fault_adr_o = fault_adr_q;
  assign fault_o     = fault_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_adr_q  <= '0;
      fault_adr_q <= '0;
      fault_q     <= 1'b0;
    end else begin
      if (accept) last_adr_q <= wbs.adr;
      if (abort_entry) begin
        fault_adr_q <= last_adr_q;
        fault_q     <= 1'b1;
      end else if (fault_clr_i) begin
        fault_q     <= 1'b0;
      end
    end
  end
`endif
endmodule
